dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single data memory (256 x 32-bit words, byte-enabled, combinational read, write committed on clock edge) between the pipeline's memory stage (core port) and the debug/program-loader port. Core has priority. An optional starvation guard forces a debug grant after a bounded wait. The block drives the memory's address, enable, byte-enable and write-data inputs and returns registered read data to the winning requester.

## Interface
- STARVE_LIMIT, 8: consecutive denied debug-request cycles before a forced debug grant (guard builds only); legal range 1..255.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- core_req / dbg_req  in  1  request valid; fields below are held stable until the matching gnt
- core_we / dbg_we  in  1  1 = write, 0 = read
- core_addr / dbg_addr  in  10  byte address; word index = addr[9:2]
- core_be / dbg_be  in  4  byte enables, already lane-aligned by the requester
- core_wdata / dbg_wdata  in  32  write data, lane-aligned
- core_gnt / dbg_gnt  out  1  combinational; access performed this cycle
- core_rvalid / dbg_rvalid  out  1  read data valid, one cycle after a read grant
- core_rdata / dbg_rdata  out  32  registered read data
- mem_byte_address  out  10; mem_write_enable  out  1; mem_read_enable  out  1; mem_byte_enable  out  4; mem_write_data  out  32  memory drive
- mem_read_data  in  32  memory combinational read data
- dbg_starved  out  1  registered; 1 while the guard is forcing a grant

## Operation
- At most one grant per cycle. A granted request completes in that cycle; the requester may present a new request the next cycle.
- Mux: the granted port's addr, be, wdata and we go to the memory. mem_write_enable = we, mem_read_enable = !we. With no grant, all mem_* outputs are 0, including byte enables.
- Arbitration, FSM states CORE_PRI and DBG_FORCE:
  - CORE_PRI: core_req wins, otherwise dbg_req wins.
  - DBG_FORCE: dbg wins regardless of core_req, for exactly one grant. Then return to CORE_PRI and clear the counter.
- Starve counter, 8 bits: increments on each cycle with dbg_req=1 and dbg_gnt=0. It clears on any dbg_gnt or when dbg_req=0. When it reaches STARVE_LIMIT, the next state is DBG_FORCE.
- Read return: on a read grant, capture mem_read_data into the granted port's rdata and pulse its rvalid for one cycle. The other port's rdata holds its last value. Writes produce no rvalid.
- Core and debug accessing the same word in back-to-back cycles: the later read sees the earlier write, because the memory commits on the edge.

## Timing
- Grant, request, memory lines: combinational, zero latency.
- Read data: 1-cycle latency, registered.
- Reset (reset_n low, asynchronous):
  - state = CORE_PRI; counter = 0.
  - rvalid = 0, rdata = 0, dbg_starved = 0.
  - Grants and all mem_* outputs forced to 0 while reset is asserted.
- Reset asserted mid-cycle: any in-flight rvalid is dropped. A write granted in the reset cycle is not performed, since mem_write_enable is forced low.
- Simultaneous requests in CORE_PRI: core granted, debug stalls. Simultaneous requests in DBG_FORCE: debug granted, core stalls one cycle.
- Debug drops its request while in DBG_FORCE: return to CORE_PRI, no grant issued.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - counter, DBG_FORCE state and dbg_starved are built.
  - STARVE_LIMIT is honoured.
- Undefined:
  - strict core priority; debug can starve indefinitely.
  - dbg_starved tied to 0; STARVE_LIMIT ignored.

## Structure
- Shared common package:
  - arb_state_t enum {CORE_PRI, DBG_FORCE}.
  - typedef mem_req_t struct {we, addr[9:0], be[3:0], wdata[31:0]}, used for both ports and the muxed memory drive.
  - constant DMEM_ADDR_W = 10.
- Natural sub-module: dmem_starve_guard (counter plus FSM), instantiated only under the macro.

## Test plan
- Core only: write 0xDEADBEEF, be=4'hF, addr 0x010, then read addr 0x010 -> core_gnt same cycle; core_rvalid one cycle after the read; core_rdata = 0xDEADBEEF.
- Debug byte write: be=4'b0100, wdata=0x00AB0000 to a word already holding 0xDEADBEEF; then core read -> 0xDEABBEEF.
- Simultaneous reads, core addr 0x000, debug addr 0x004 -> core granted cycle 0; debug granted cycle 1; each rvalid on its own port, one cycle after its grant, with the correct word.
- Guard on, STARVE_LIMIT=3, core_req held high, debug read pending -> dbg_starved=1 and dbg_gnt in cycle 3; core granted in cycles 0-2 and 4+.
- Guard off, same stimulus for 100 cycles -> dbg_gnt never asserted; dbg_starved=0.
- Assert reset_n low in the cycle after a read grant -> rvalid and rdata go to 0 immediately. Write issued in the reset cycle -> memory word unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = 4;

    // Arbitration state: normal core priority, or one forced debug grant.
    typedef enum logic [0:0] {
        CORE_PRI  = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_t;

    // One memory access: the shape of both requester ports and the muxed memory drive.
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_BE_W-1:0]   be;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_starve_guard.sv
// Debug starvation guard: counts consecutive denied debug-request cycles and
// forces exactly one debug grant once STARVE_LIMIT is reached.
// Compiled only in builds with DMEM_ARB_STARVE_GUARD_EN defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_starve_guard
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [7:0] LIMIT_CNT = 8'(STARVE_LIMIT);

    arb_state_t state;
    arb_state_t state_next;
    logic [7:0] starve_cnt;
    logic [7:0] starve_cnt_next;

    // Next-state and counter: a denied debug request extends the streak, anything else clears it.
    always_comb begin
        state_next      = CORE_PRI;
        starve_cnt_next = '0;
        if (dbg_req && !dbg_gnt) begin
            starve_cnt_next = starve_cnt + 8'd1;
            if (state == CORE_PRI && starve_cnt_next == LIMIT_CNT) begin
                state_next = DBG_FORCE;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CORE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // The forced-grant indication comes straight from the state register.
    assign force_dbg = (state == DBG_FORCE);

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the shared 256 x 32 data memory. Core has priority;
// read data returns registered one cycle after a read grant.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [DMEM_ADDR_W-1:0] core_addr,
    input  logic [DMEM_BE_W-1:0]   core_be,
    input  logic [DMEM_DATA_W-1:0] core_wdata,
    output logic                   core_gnt,
    output logic                   core_rvalid,
    output logic [DMEM_DATA_W-1:0] core_rdata,

    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [DMEM_ADDR_W-1:0] dbg_addr,
    input  logic [DMEM_BE_W-1:0]   dbg_be,
    input  logic [DMEM_DATA_W-1:0] dbg_wdata,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [DMEM_DATA_W-1:0] dbg_rdata,

    output logic [DMEM_ADDR_W-1:0] mem_byte_address,
    output logic                   mem_write_enable,
    output logic                   mem_read_enable,
    output logic [DMEM_BE_W-1:0]   mem_byte_enable,
    output logic [DMEM_DATA_W-1:0] mem_write_data,
    input  logic [DMEM_DATA_W-1:0] mem_read_data,

    output logic                   dbg_starved
);

    // The counter is 8 bits wide and a limit of 0 would never fire.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    mem_req_t core_r;
    mem_req_t dbg_r;
    mem_req_t mem_drv;
    logic     force_dbg;
    logic     any_gnt;

    assign core_r = '{we: core_we, addr: core_addr, be: core_be, wdata: core_wdata};
    assign dbg_r  = '{we: dbg_we,  addr: dbg_addr,  be: dbg_be,  wdata: dbg_wdata};

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk       (clk),
        .reset_n   (reset_n),
        .dbg_req   (dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );
    assign dbg_starved = force_dbg;
`else
    assign force_dbg   = 1'b0;
    assign dbg_starved = 1'b0;
`endif

    // Grant selection: a forced debug slot beats the core, otherwise core first.
    // Reset gates all grants so nothing reaches the memory while reset is held.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (reset_n) begin
            if (force_dbg) begin
                dbg_gnt = dbg_req;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else begin
                dbg_gnt = dbg_req;
            end
        end
    end

    // Memory drive mux: the winner's access, or all zeros when nobody is granted.
    always_comb begin
        mem_drv = '0;
        if (core_gnt) begin
            mem_drv = core_r;
        end else if (dbg_gnt) begin
            mem_drv = dbg_r;
        end
    end

    assign any_gnt          = core_gnt | dbg_gnt;
    assign mem_byte_address = mem_drv.addr;
    assign mem_byte_enable  = mem_drv.be;
    assign mem_write_data   = mem_drv.wdata;
    assign mem_write_enable = any_gnt &  mem_drv.we;
    assign mem_read_enable  = any_gnt & ~mem_drv.we;

    // Core read return: capture on a core read grant, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            core_rvalid <= core_gnt & ~core_we;
            if (core_gnt && !core_we) begin
                core_rdata <= mem_read_data;
            end
        end
    end

    // Debug read return: capture on a debug read grant, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbitration rules.
// Expectations follow the DMEM_ARB_STARVE_GUARD_EN setting of the build.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned LIMIT = 3;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_req;
    logic        dbg_req;
    mem_req_t    core_q;
    mem_req_t    dbg_q;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, dbg_starved;
    logic [31:0] core_rdata, dbg_rdata;
    logic [9:0]  mem_byte_address;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data, mem_read_data;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .core_req         (core_req),
        .core_we          (core_q.we),
        .core_addr        (core_q.addr),
        .core_be          (core_q.be),
        .core_wdata       (core_q.wdata),
        .core_gnt         (core_gnt),
        .core_rvalid      (core_rvalid),
        .core_rdata       (core_rdata),
        .dbg_req          (dbg_req),
        .dbg_we           (dbg_q.we),
        .dbg_addr         (dbg_q.addr),
        .dbg_be           (dbg_q.be),
        .dbg_wdata        (dbg_q.wdata),
        .dbg_gnt          (dbg_gnt),
        .dbg_rvalid       (dbg_rvalid),
        .dbg_rdata        (dbg_rdata),
        .mem_byte_address (mem_byte_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .dbg_starved      (dbg_starved)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Memory the arbiter drives: combinational read, byte-enabled write on the edge.
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    assign mem_read_data = mem[mem_byte_address[9:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_byte_address[9:2]] <= apply_be(mem[mem_byte_address[9:2]], mem_write_data,
                                                   mem_byte_enable);
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    bit          exp_core_rvalid, exp_dbg_rvalid;
    logic [31:0] exp_core_rdata, exp_dbg_rdata;
    int          streak;
    bit          forced;
    bit          last_core_gnt, last_dbg_gnt, obs_core_gnt, obs_dbg_gnt, obs_starved;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_core_rvalid = 1'b0;
        exp_dbg_rvalid  = 1'b0;
        exp_core_rdata  = '0;
        exp_dbg_rdata   = '0;
        streak          = 0;
        forced          = 1'b0;
    endtask

    function automatic mem_req_t rand_req();
        mem_req_t   r;
        logic [7:0] w;
        w       = 8'($urandom_range(0, 7));
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = {w, 2'($urandom_range(0, 3))};
        r.be    = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    // Called with inputs already applied just after a rising edge; returns 1 time unit after the next.
    task automatic cycle();
        bit          cg, dg;
        mem_req_t    win;
        logic [47:0] exp_drv;
        logic [31:0] rd_word;
        @(negedge clk);
        check("core_rvalid", 64'(core_rvalid), 64'(exp_core_rvalid));
        check("core_rdata", 64'(core_rdata), 64'(exp_core_rdata));
        check("dbg_rvalid", 64'(dbg_rvalid), 64'(exp_dbg_rvalid));
        check("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rdata));
        check("dbg_starved", 64'(dbg_starved), 64'(forced));
        cg = 1'b0;
        dg = 1'b0;
        if (forced)        dg = dbg_req;
        else if (core_req) cg = 1'b1;
        else               dg = dbg_req;
        check("core_gnt", 64'(core_gnt), 64'(cg));
        check("dbg_gnt", 64'(dbg_gnt), 64'(dg));
        win     = cg ? core_q : (dg ? dbg_q : '0);
        exp_drv = (cg || dg) ? {win.we, !win.we, win.be, win.addr, win.wdata} : '0;
        check("mem_drive", 64'({mem_write_enable, mem_read_enable, mem_byte_enable,
                                mem_byte_address, mem_write_data}), 64'(exp_drv));
        obs_core_gnt  = core_gnt;
        obs_dbg_gnt   = dbg_gnt;
        obs_starved   = dbg_starved;
        last_core_gnt = cg;
        last_dbg_gnt  = dg;
        rd_word       = ref_mem[win.addr[9:2]];
        @(posedge clk);
        exp_core_rvalid = cg && !win.we;
        exp_dbg_rvalid  = dg && !win.we;
        if (exp_core_rvalid) exp_core_rdata = rd_word;
        if (exp_dbg_rvalid)  exp_dbg_rdata  = rd_word;
        if ((cg || dg) && win.we) ref_mem[win.addr[9:2]] = apply_be(ref_mem[win.addr[9:2]], win.wdata, win.be);
        if (dbg_req && !dg) streak++;
        else                streak = 0;
        forced = GUARD && (streak == int'(LIMIT));
        #1;
    endtask

    initial begin
        int first_dbg, starved_at, core_cnt;

        reset_n  = 1'b0;
        core_req = 1'b0;
        dbg_req  = 1'b0;
        core_q   = '0;
        dbg_q    = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Requests during reset are ignored and nothing reaches the memory.
        repeat (2) @(posedge clk);
        #1 core_req = 1'b1;
        core_q = '{we: 1'b1, addr: 10'h010, be: 4'hF, wdata: 32'h1234_5678};
        #1;
        check("rst_gnt_drive", 64'({core_gnt, dbg_gnt, mem_write_enable, mem_read_enable, mem_byte_enable,
                                    mem_byte_address, mem_write_data}), 64'h0);
        check("rst_flags", 64'({core_rvalid, dbg_rvalid, dbg_starved}), 64'h0);
        check("rst_rdata", {core_rdata, dbg_rdata}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        core_req = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;

        // Core write then read back.
        core_req = 1'b1;
        core_q   = '{we: 1'b1, addr: 10'h010, be: 4'hF, wdata: 32'hDEAD_BEEF};
        cycle();
        check("t1_write_gnt", 64'(obs_core_gnt), 64'h1);
        core_q = '{we: 1'b0, addr: 10'h010, be: 4'hF, wdata: 32'h0};
        cycle();
        core_req = 1'b0;
        check("t1_rvalid", 64'(core_rvalid), 64'h1);
        check("t1_rdata", 64'(core_rdata), 64'hDEAD_BEEF);
        cycle();

        // Debug byte-lane write merged into the existing word.
        dbg_req = 1'b1;
        dbg_q   = '{we: 1'b1, addr: 10'h010, be: 4'b0100, wdata: 32'h00AB_0000};
        cycle();
        dbg_req  = 1'b0;
        core_req = 1'b1;
        core_q   = '{we: 1'b0, addr: 10'h010, be: 4'hF, wdata: 32'h0};
        cycle();
        core_req = 1'b0;
        check("t2_merged", 64'(core_rdata), 64'hDEAB_BEEF);
        cycle();

        // Simultaneous reads: core first, debug the following cycle.
        core_req = 1'b1;
        core_q   = '{we: 1'b0, addr: 10'h000, be: 4'hF, wdata: 32'h0};
        dbg_req  = 1'b1;
        dbg_q    = '{we: 1'b0, addr: 10'h004, be: 4'hF, wdata: 32'h0};
        cycle();
        check("t3_gnt_c0", 64'({obs_core_gnt, obs_dbg_gnt}), 64'h2);
        core_req = 1'b0;
        check("t3_core_ret", 64'({core_rvalid, dbg_rvalid, core_rdata}), {30'h0, 2'b10, 32'hC0DE_0000});
        cycle();
        check("t3_gnt_c1", 64'({obs_core_gnt, obs_dbg_gnt}), 64'h1);
        dbg_req = 1'b0;
        check("t3_dbg_ret", 64'({core_rvalid, dbg_rvalid, dbg_rdata}), {30'h0, 2'b01, 32'hC0DE_0001});
        cycle();

        // Core hammers the memory while a debug read waits.
        core_req   = 1'b1;
        core_q     = '{we: 1'b0, addr: 10'h020, be: 4'hF, wdata: 32'h0};
        dbg_req    = 1'b1;
        dbg_q      = '{we: 1'b0, addr: 10'h024, be: 4'hF, wdata: 32'h0};
        first_dbg  = -1;
        starved_at = -1;
        core_cnt   = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (obs_dbg_gnt && first_dbg < 0) first_dbg = i;
            if (obs_starved && starved_at < 0) starved_at = i;
            if (obs_core_gnt) core_cnt++;
            if (last_dbg_gnt) dbg_req = 1'b0;
            if (GUARD && i == 7) break;
        end
        check("t4_first_dbg_gnt", 64'(first_dbg), GUARD ? 64'd3 : 64'(-1));
        check("t4_starved_cycle", 64'(starved_at), GUARD ? 64'd3 : 64'(-1));
        check("t4_core_gnt_count", 64'(core_cnt), GUARD ? 64'd7 : 64'd100);
        core_req = 1'b0;
        cycle();
        if (last_dbg_gnt) dbg_req = 1'b0;
        cycle();

        // Reset lands the cycle after a read grant; a write offered during reset is dropped.
        core_req = 1'b1;
        core_q   = '{we: 1'b0, addr: 10'h010, be: 4'hF, wdata: 32'h0};
        cycle();
        check("t5_pre_rvalid", 64'(core_rvalid), 64'h1);
        core_q = '{we: 1'b1, addr: 10'h010, be: 4'hF, wdata: 32'hFFFF_FFFF};
        #1 reset_n = 1'b0;
        #1;
        check("t5_rvalid_drop", 64'(core_rvalid), 64'h0);
        check("t5_rdata_clear", 64'(core_rdata), 64'h0);
        check("t5_no_write", 64'({core_gnt, mem_write_enable}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        core_req = 1'b0;
        reset_n  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        core_req = 1'b1;
        core_q   = '{we: 1'b0, addr: 10'h010, be: 4'hF, wdata: 32'h0};
        cycle();
        core_req = 1'b0;
        check("t5_word_kept", 64'(core_rdata), 64'hDEAB_BEEF);
        cycle();

        // Random traffic on a small address window so ports collide on the same words.
        for (int n = 0; n < 3000; n++) begin
            if (last_core_gnt || !core_req) begin
                core_req = ($urandom_range(0, 3) != 0);
                core_q   = rand_req();
            end
            if (last_dbg_gnt || !dbg_req) begin
                dbg_req = ($urandom_range(0, 1) == 1);
                dbg_q   = rand_req();
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
